// File: rtl/bus_arbiter.sv
// Round-robin arbiter letting two bus masters share one slave port.
// Optional grant watchdog enabled with `define BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int XLEN           = 32,
    parameter int SLAVE_WIDTH    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        m0_req,
    input  logic                        m0_wen,
    input  logic [2:0]                  m0_mode,
    input  logic [XLEN-SLAVE_WIDTH-1:0] m0_addr,
    input  logic [SLAVE_WIDTH-1:0]      m0_num,
    input  logic [XLEN-1:0]             m0_dat_o,
    output logic [XLEN-1:0]             m0_dat_i,
    output logic                        m0_ready,
    input  logic                        m1_req,
    input  logic                        m1_wen,
    input  logic [2:0]                  m1_mode,
    input  logic [XLEN-SLAVE_WIDTH-1:0] m1_addr,
    input  logic [SLAVE_WIDTH-1:0]      m1_num,
    input  logic [XLEN-1:0]             m1_dat_o,
    output logic [XLEN-1:0]             m1_dat_i,
    output logic                        m1_ready,
    output logic [1:0]                  gnt,
    output logic                        bus_req,
    output logic                        bus_wen,
    output logic [2:0]                  bus_mode,
    output logic [XLEN-SLAVE_WIDTH-1:0] bus_addr,
    output logic [SLAVE_WIDTH-1:0]      bus_num,
    output logic [XLEN-1:0]             bus_dat_o,
    input  logic [XLEN-1:0]             bus_dat_i,
    input  logic                        bus_ready,
    output logic                        bus_timeout
);

    localparam int AW = XLEN - SLAVE_WIDTH;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last_grant;
    logic       last_nxt;
    logic       sel0;
    logic       sel1;
    logic       expire;

    assign sel0 = (state == GRANT0);
    assign sel1 = (state == GRANT1);

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] wd_cnt;
    logic          to_flag;

    // Slave completion in the expiry cycle wins over the watchdog.
    assign expire = (sel0 | sel1) && !bus_ready &&
                    (wd_cnt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            if (state == IDLE)
                wd_cnt <= '0;
            else if (!bus_ready)
                wd_cnt <= wd_cnt + 1'b1;
            if (expire)
                to_flag <= 1'b1;
        end
    end

    assign bus_timeout = to_flag;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign expire         = 1'b0;
    assign bus_timeout    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        last_nxt  = last_grant;
        case (state)
            IDLE: begin
                // last_grant set means m1 went last, so m0 wins a tie.
                if (m0_req && (!m1_req || last_grant))
                    state_nxt = GRANT0;
                else if (m1_req)
                    state_nxt = GRANT1;
            end
            GRANT0: begin
                if (bus_ready || expire) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b0;
                end
            end
            GRANT1: begin
                if (bus_ready || expire) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_nxt;
        end
    end

    assign gnt     = {sel1, sel0};
    assign bus_req = sel0 | sel1;

    assign bus_wen   = (sel0 & m0_wen) | (sel1 & m1_wen);
    assign bus_mode  = ({3{sel0}} & m0_mode) | ({3{sel1}} & m1_mode);
    assign bus_addr  = ({AW{sel0}} & m0_addr) | ({AW{sel1}} & m1_addr);
    assign bus_num   = ({SLAVE_WIDTH{sel0}} & m0_num) |
                       ({SLAVE_WIDTH{sel1}} & m1_num);
    assign bus_dat_o = ({XLEN{sel0}} & m0_dat_o) |
                       ({XLEN{sel1}} & m1_dat_o);

    assign m0_ready = sel0 & (bus_ready | expire);
    assign m1_ready = sel1 & (bus_ready | expire);

    assign m0_dat_i = !sel0 ? '0 : (expire ? '1 : bus_dat_i);
    assign m1_dat_i = !sel1 ? '0 : (expire ? '1 : bus_dat_i);

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised bench for bus_arbiter against a transaction-level model.
// Build with BUS_ARB_TIMEOUT_EN defined to cover the watchdog.
module tb_bus_arbiter;

    localparam int XLEN = 32;
    localparam int SW   = 4;
    localparam int AW   = XLEN - SW;
    localparam int TO   = 16;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            m0_req, m0_wen, m1_req, m1_wen;
    logic [2:0]      m0_mode, m1_mode;
    logic [AW-1:0]   m0_addr, m1_addr;
    logic [SW-1:0]   m0_num, m1_num;
    logic [XLEN-1:0] m0_dat_o, m1_dat_o, m0_dat_i, m1_dat_i;
    logic            m0_ready, m1_ready;
    logic [1:0]      gnt;
    logic            bus_req, bus_wen, bus_ready, bus_timeout;
    logic [2:0]      bus_mode;
    logic [AW-1:0]   bus_addr;
    logic [SW-1:0]   bus_num;
    logic [XLEN-1:0] bus_dat_o, bus_dat_i;

    always #5 clk = ~clk;

    bus_arbiter #(
        .XLEN(XLEN), .SLAVE_WIDTH(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_mode(m0_mode),
        .m0_addr(m0_addr), .m0_num(m0_num), .m0_dat_o(m0_dat_o),
        .m0_dat_i(m0_dat_i), .m0_ready(m0_ready),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_mode(m1_mode),
        .m1_addr(m1_addr), .m1_num(m1_num), .m1_dat_o(m1_dat_o),
        .m1_dat_i(m1_dat_i), .m1_ready(m1_ready),
        .gnt(gnt), .bus_req(bus_req), .bus_wen(bus_wen),
        .bus_mode(bus_mode), .bus_addr(bus_addr), .bus_num(bus_num),
        .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
        .bus_ready(bus_ready), .bus_timeout(bus_timeout)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: who owns the bus (-1 none), who went last, cycles waited.
    int own     = -1;
    int last    = 1;
    int waited  = 0;
    bit to_flag = 1'b0;
    bit d0, d1;
    bit busy;
    int dly;

    function automatic bit expired();
        return TO_EN && own >= 0 && !bus_ready && waited == TO;
    endfunction

    task automatic settle();
        logic            ew;
        logic [2:0]      em;
        logic [AW-1:0]   ea;
        logic [SW-1:0]   en;
        logic [XLEN-1:0] ed;
        logic [XLEN-1:0] rd;
        bit              ex;
        #1;
        ew = 1'b0; em = '0; ea = '0; en = '0; ed = '0;
        if (own == 0) begin
            ew = m0_wen; em = m0_mode; ea = m0_addr;
            en = m0_num; ed = m0_dat_o;
        end else if (own == 1) begin
            ew = m1_wen; em = m1_mode; ea = m1_addr;
            en = m1_num; ed = m1_dat_o;
        end
        ex = expired();
        rd = ex ? '1 : bus_dat_i;
        d0 = (own == 0) && (bus_ready || ex);
        d1 = (own == 1) && (bus_ready || ex);
        check("gnt", gnt, own == 0 ? 2'b01 : own == 1 ? 2'b10 : 2'b00);
        check("bus_req", bus_req, own >= 0);
        check("bus_wen", bus_wen, ew);
        check("bus_mode", bus_mode, em);
        check("bus_addr", bus_addr, ea);
        check("bus_num", bus_num, en);
        check("bus_dat_o", bus_dat_o, ed);
        check("m0_ready", m0_ready, d0);
        check("m1_ready", m1_ready, d1);
        check("m0_dat_i", m0_dat_i, own == 0 ? rd : '0);
        check("m1_dat_i", m1_dat_i, own == 1 ? rd : '0);
        check("bus_timeout", bus_timeout, to_flag);
    endtask

    task automatic adv();
        bit ex;
        ex = expired();
        if (own < 0) begin
            waited = 0;
            if (m0_req && m1_req)
                own = 1 - last;
            else if (m0_req)
                own = 0;
            else if (m1_req)
                own = 1;
        end else if (bus_ready || ex) begin
            if (!bus_ready)
                to_flag = 1'b1;
            last = own;
            own  = -1;
        end else begin
            waited++;
        end
        @(negedge clk);
    endtask

    task automatic new_req(int x);
        if (x == 0) begin
            m0_req = 1'b1; m0_wen = 1'($urandom); m0_mode = 3'($urandom);
            m0_addr = AW'($urandom); m0_num = SW'($urandom);
            m0_dat_o = $urandom;
        end else begin
            m1_req = 1'b1; m1_wen = 1'($urandom); m1_mode = 3'($urandom);
            m1_addr = AW'($urandom); m1_num = SW'($urandom);
            m1_dat_o = $urandom;
        end
    endtask

    // renew: 0 drop after ready, 1 re-request at once, 2 coin flip.
    task automatic drive(int renew, int p_new, int max_dly, bit spur);
        if (d0) begin
            if (renew == 1 || (renew == 2 && $urandom_range(0, 1) == 1))
                new_req(0);
            else
                m0_req = 1'b0;
        end else if (!m0_req && int'($urandom_range(0, 99)) < p_new) begin
            new_req(0);
        end
        if (d1) begin
            if (renew == 1 || (renew == 2 && $urandom_range(0, 1) == 1))
                new_req(1);
            else
                m1_req = 1'b0;
        end else if (!m1_req && int'($urandom_range(0, 99)) < p_new) begin
            new_req(1);
        end
        if (own >= 0) begin
            if (!busy) begin
                busy = 1'b1;
                dly  = int'($urandom_range(0, max_dly));
            end
            if (dly == 0) begin
                bus_ready = 1'b1;
                bus_dat_i = $urandom;
            end else begin
                bus_ready = 1'b0;
                dly--;
            end
        end else begin
            busy      = 1'b0;
            bus_ready = spur && ($urandom_range(0, 3) == 0);
            bus_dat_i = $urandom;
        end
    endtask

    task automatic clear_inputs();
        m0_req = 0; m0_wen = 0; m0_mode = 0; m0_addr = 0;
        m0_num = 0; m0_dat_o = 0;
        m1_req = 0; m1_wen = 0; m1_mode = 0; m1_addr = 0;
        m1_num = 0; m1_dat_o = 0;
        bus_ready = 0; bus_dat_i = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        own = -1; last = 1; waited = 0; to_flag = 1'b0;
        busy = 1'b0; d0 = 1'b0; d1 = 1'b0;
        @(negedge clk);
        settle();
        rst = 1'b1;
        adv();
    endtask

    initial begin
        int         k;
        int         ndone;
        int         viol;
        logic [1:0] gq[$];
        int         order[$];

        clear_inputs();
        do_reset();

        // Single m0 read, slave answers on the third granted cycle.
        m0_req = 1; m0_mode = 3'b100; m0_addr = AW'(32'h40); m0_num = 4'd1;
        settle(); adv();
        settle(); check("read_gnt", gnt, 2'b01); adv();
        settle(); adv();
        bus_ready = 1; bus_dat_i = 32'h12345678;
        settle();
        check("read_dat", m0_dat_i, 32'h12345678);
        check("read_rdy", m0_ready, 1);
        adv();
        m0_req = 0; bus_ready = 0;
        settle(); check("read_idle", bus_req, 0); adv();

        // Simultaneous requests after reset: m0, idle, m1.
        do_reset();
        new_req(0); new_req(1);
        for (int i = 0; i < 4; i++) begin
            settle(); gq.push_back(gnt); adv(); drive(0, 0, 0, 0);
        end
        check("tie_seq0", gq[0], 2'b00);
        check("tie_seq1", gq[1], 2'b01);
        check("tie_seq2", gq[2], 2'b00);
        check("tie_seq3", gq[3], 2'b10);

        // Continuous contention: grants must alternate.
        do_reset();
        new_req(0); new_req(1);
        ndone = 0; viol = 0;
        for (int i = 0; i < 200 && ndone < 6; i++) begin
            settle();
            if (gnt == 2'b01 && m1_ready) viol++;
            if (d0 || d1) begin
                order.push_back(d1 ? 1 : 0);
                ndone++;
            end
            adv(); drive(1, 0, 3, 0);
        end
        check("rr_count", ndone, 6);
        for (int i = 0; i < order.size(); i++)
            check("rr_alt", order[i], i % 2);
        check("rr_m1_in_g0", viol, 0);

        // m1 write pass-through with idle m0 fields non-zero.
        do_reset();
        m0_addr = AW'(32'hABCDE); m0_dat_o = 32'h11111111; m0_num = 4'd9;
        m1_req = 1; m1_wen = 1; m1_addr = AW'(32'h000100); m1_num = 4'd3;
        m1_dat_o = 32'hCAFEF00D; m1_mode = 3'b010;
        bus_dat_i = 32'h55AA55AA;
        settle(); adv();
        settle();
        check("wr_wen", bus_wen, 1);
        check("wr_addr", bus_addr, 32'h100);
        check("wr_num", bus_num, 3);
        check("wr_dat", bus_dat_o, 32'hCAFEF00D);
        check("wr_mode", bus_mode, 3'b010);
        bus_ready = 1;
        settle();
        check("wr_m1_rdy", m1_ready, 1);
        check("wr_m0_rdy", m0_ready, 0);
        check("wr_m0_dat", m0_dat_i, 0);
        adv();
        m1_req = 0; bus_ready = 0;
        settle(); adv();

        // Asynchronous reset in the middle of a grant.
        do_reset();
        new_req(0);
        settle(); adv();
        settle();
        #2 rst = 1'b0;
        #1;
        check("arst_req", bus_req, 0);
        check("arst_gnt", gnt, 0);
        own = -1; last = 1; waited = 0; busy = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        new_req(1);
        settle(); adv();
        settle(); check("arst_m1_gnt", gnt, 2'b10);
        bus_ready = 1;
        settle(); adv();
        m1_req = 0; bus_ready = 0;
        settle(); adv();

`ifdef BUS_ARB_TIMEOUT_EN
        // Silent slave: watchdog completes the grant.
        do_reset();
        new_req(0);
        settle(); adv();
        k = 0;
        for (int i = 0; i < 40; i++) begin
            settle();
            if (m0_ready) break;
            adv();
            k++;
        end
        check("to_wait", k, TO);
        check("to_dat", m0_dat_i, 32'hFFFFFFFF);
        adv();
        m0_req = 0;
        settle(); check("to_flag", bus_timeout, 1); adv();
`endif

        // Random traffic; any watchdog flag set above must persist.
        for (int i = 0; i < 3000; i++) begin
            settle(); adv(); drive(2, 30, 3, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, single-slave arbiter for the system bus (bus_req/bus_wen/bus_mode/bus_addr/bus_num/bus_ready handshake).
- Lets a second master (DMA / debug engine) share the bus with the CPU.
- Sits between the masters and the existing slave decode in the top level, and is transparent to slaves.
- Arbitration is round-robin; a grant is held for exactly one transaction, ending on bus_ready.

Parameters:
- XLEN, 32, data and address word width
- SLAVE_WIDTH, 4, width of the slave-select field bus_num
- TIMEOUT_CYCLES, 255, cycles a granted transaction may wait for bus_ready (used only with the optional feature)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  master request, held until its ready pulse
- m0_wen / m1_wen  in  1  write enable
- m0_mode / m1_mode  in  3  access size/sign mode
- m0_addr / m1_addr  in  XLEN-SLAVE_WIDTH  in-slave address
- m0_num / m1_num  in  SLAVE_WIDTH  slave select
- m0_dat_o / m1_dat_o  in  XLEN  write data
- m0_dat_i / m1_dat_i  out  XLEN  read data
- m0_ready / m1_ready  out  1  transaction-complete pulse
- gnt  out  2  one-hot current grant: bit0 = m0, bit1 = m1
- bus_req  out  1  request to slave
- bus_wen  out  1  write enable to slave
- bus_mode  out  3  mode to slave
- bus_addr  out  XLEN-SLAVE_WIDTH  address to slave
- bus_num  out  SLAVE_WIDTH  slave select
- bus_dat_o  out  XLEN  write data to slave
- bus_dat_i  in  XLEN  read data from slave
- bus_ready  in  1  slave completion
- bus_timeout  out  1  sticky timeout flag

Behaviour:
- State machine: IDLE, GRANT0, GRANT1, plus a registered last_grant bit.
- Reset (rst=0, asynchronous): state=IDLE, last_grant=1 so m0 wins first, gnt=0, bus_timeout=0, all bus_* outputs 0, m*_ready=0, m*_dat_i=0.
- IDLE transitions, evaluated on rising edge:
  - only m0_req -> GRANT0
  - only m1_req -> GRANT1
  - both requesting -> grant the master opposite last_grant
  - neither requesting -> stay in IDLE
- Arbitration latency: request seen on edge N -> gnt and bus_req asserted after edge N, one cycle.
- GRANTx output muxing:
  - bus_req = 1, regardless of mx_req.
  - bus_wen/mode/addr/num/dat_o are a combinational pass-through of master x.
  - mx_dat_i = bus_dat_i and mx_ready = bus_ready, both combinational.
  - The non-granted master sees ready=0 and dat_i=0.
- GRANTx exit: on an edge with bus_ready=1 -> IDLE, and last_grant=x.
- Mandatory IDLE cycle: bus_req is low for at least one cycle between transactions. A master issuing back-to-back requests re-arbitrates, so round-robin alternates under contention.
- Outputs in IDLE: bus_req=0, all other bus_* outputs 0. bus_ready arriving in IDLE is ignored and never forwarded.
- Master drops mx_req mid-grant (protocol violation): grant is still held until bus_ready; the ready pulse is still delivered.
- Reset mid-transaction: immediate return to IDLE with bus_req=0 asynchronously; the pending ready is lost.
- Without the optional feature, bus_timeout is tied to 0.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit-or-wider watchdog counter clears on entry to GRANTx and increments every granted cycle without bus_ready.
  - When count reaches TIMEOUT_CYCLES, the arbiter drives mx_ready=1 and mx_dat_i={XLEN{1'b1}} for one cycle, then returns to IDLE, sets last_grant=x, and sets bus_timeout=1.
  - bus_timeout is sticky and cleared only by reset.
  - bus_ready in the same cycle as expiry takes priority: normal completion, no flag.
- When undefined: no counter; a grant waits indefinitely for bus_ready; bus_timeout is constant 0.

Test Plan:
- m0 read only, slave returns ready 2 cycles after bus_req with data 0x12345678 -> gnt=01 one cycle after request, m0_dat_i=0x12345678 with m0_ready pulse, bus_req low the next cycle.
- m0 and m1 request on the same edge after reset -> m0 served first, then one IDLE cycle, then m1 served (gnt sequence 01, 00, 10).
- Both hold requests continuously for 6 transactions -> grants strictly alternate m0, m1, m0, m1, …; m1_ready never asserts while gnt=01.
- m1 write addr=0x000100, num=3, dat=0xCAFEF00D, mode=3'b010 -> bus_* outputs show exactly these values during GRANT1 with bus_wen=1; m0 outputs stay 0.
- rst pulled low while in GRANT0 before ready -> bus_req=0 and gnt=00 without waiting for a clock edge; after release, a new m1 request is granted normally.
- With BUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never responds -> m0_ready pulse after 16 granted cycles, m0_dat_i=0xFFFFFFFF, bus_timeout=1 and stays 1 through later normal transactions.
